// File: rtl/psa_arb_if.sv
// psa_arb_if: request/result handshake bundle for psa_arb.
interface psa_arb_if;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic res_valid, res_ready, res_src;
  logic [15:0] res_sum;
  logic [3:0] res_ovf;
  modport master(
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    input req0_ready, req1_ready, res_valid, res_sum, res_src, res_ovf
  );
  modport slave(
    input req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    output req0_ready, req1_ready, res_valid, res_sum, res_src, res_ovf
  );
endinterface

// File: rtl/psa_arb.sv
// psa_arb: round-robin two-requester packed 4x4 saturating adder with a one-entry result register.
// Defining PSA_ARB_STICKY_EN enables the ovf_sticky flag; otherwise it is tied low.
module psa_arb #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  psa_arb_if.slave         bus,
  input  logic             clr_sticky,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nx;
  logic last, grant, slot_free, acc;
  logic [15:0] a_sel, b_sel, sum;
  logic [3:0] ovf;
  always_comb begin
    slot_free = (state == EMPTY) || bus.res_ready;
    grant = (bus.req0_valid && bus.req1_valid) ? ~last : bus.req1_valid;
    bus.req0_ready = rst_n && slot_free && !grant && bus.req0_valid;
    bus.req1_ready = rst_n && slot_free && grant && bus.req1_valid;
    acc = bus.req0_ready || bus.req1_ready;
    state_nx = acc ? FULL : (bus.res_ready ? EMPTY : state);
    bus.res_valid = state == FULL;
    a_sel = grant ? bus.req1_a : bus.req0_a;
    b_sel = grant ? bus.req1_b : bus.req0_b;
  end
  // a 5-bit sign-extended sum overflows 4 bits exactly when its top two bits differ
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [4:0] s;
    assign s = {a_sel[4*k+3], a_sel[4*k+:4]} + {b_sel[4*k+3], b_sel[4*k+:4]};
    assign ovf[k] = s[4] ^ s[3];
    assign sum[4*k+:4] = ovf[k] ? (s[4] ? 4'h8 : 4'h7) : s[3:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      last <= 1'b1;
      bus.res_sum <= '0;
      bus.res_src <= 1'b0;
      bus.res_ovf <= '0;
      op_count <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        last <= grant;
        bus.res_sum <= sum;
        bus.res_src <= grant;
        bus.res_ovf <= ovf;
        op_count <= op_count + 1'b1;
      end
    end
`ifdef PSA_ARB_STICKY_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_sticky <= 1'b0;
    else if (acc && |ovf) ovf_sticky <= 1'b1;
    else if (clr_sticky) ovf_sticky <= 1'b0;
`else
  logic unused_clr;
  assign unused_clr = clr_sticky;
  assign ovf_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_psa_arb.sv
// tb_psa_arb: directed bench for psa_arb with a per-cycle behavioural model and literal pins.
module tb_psa_arb;
`ifdef PSA_ARB_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clr_sticky = 1'b0;
  logic ovf_sticky;
  logic [7:0] op_count;
  int checks = 0;
  int errors = 0;
  psa_arb_if bus();
  psa_arb #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky), .op_count(op_count)
  );
  always #5 clk = ~clk;
  bit m_valid, m_src, m_last, m_sticky;
  logic [15:0] m_sum;
  logic [3:0] m_ovf;
  int m_cnt;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic void lane_add(input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] s, output logic [3:0] o);
    for (int k = 0; k < 4; k++) begin
      int xa, xb, x;
      xa = $signed(a[4*k+:4]);
      xb = $signed(b[4*k+:4]);
      x = xa + xb;
      o[k] = (x > 7) || (x < -8);
      if (x > 7) x = 7;
      if (x < -8) x = -8;
      s[4*k+:4] = 4'(x);
    end
  endfunction
  // model: decides each edge's winner from the arbitration rules, not from the DUT
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_valid = 0; m_src = 0; m_last = 1; m_sticky = 0; m_sum = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      bit free, take, pick;
      logic [15:0] s;
      logic [3:0] o;
      free = !m_valid || bus.res_ready;
      take = free && (bus.req0_valid || bus.req1_valid);
      if (bus.req0_valid && bus.req1_valid) pick = (m_last == 0);
      else pick = bus.req1_valid;
      o = 0;
      if (take) begin
        if (pick) lane_add(bus.req1_a, bus.req1_b, s, o);
        else lane_add(bus.req0_a, bus.req0_b, s, o);
        m_sum = s; m_ovf = o; m_src = pick; m_last = pick; m_valid = 1;
        m_cnt = (m_cnt + 1) % 256;
      end else if (bus.res_ready) m_valid = 0;
      if (STICKY) begin
        if (take && o != 0) m_sticky = 1;
        else if (clr_sticky) m_sticky = 0;
      end
    end
  always @(negedge clk) begin
    bit free, er0, er1;
    free = !m_valid || bus.res_ready;
    er0 = rst_n && free && bus.req0_valid && (!bus.req1_valid || m_last == 1);
    er1 = rst_n && free && bus.req1_valid && (!bus.req0_valid || m_last == 0);
    chk("m_req0_ready", 32'(bus.req0_ready), 32'(er0));
    chk("m_req1_ready", 32'(bus.req1_ready), 32'(er1));
    chk("m_res_valid", 32'(bus.res_valid), 32'(m_valid));
    chk("m_op_count", 32'(op_count), 32'(m_cnt));
    chk("m_ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
    if (m_valid) begin
      chk("m_res_sum", 32'(bus.res_sum), 32'(m_sum));
      chk("m_res_src", 32'(bus.res_src), 32'(m_src));
      chk("m_res_ovf", 32'(bus.res_ovf), 32'(m_ovf));
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input bit v0, input logic [15:0] a0, input logic [15:0] b0,
                         input bit v1, input logic [15:0] a1, input logic [15:0] b1);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
  endtask
  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask
  initial begin
    set_req(0, 0, 0, 0, 0, 0);
    bus.res_ready = 1'b1;
    #1 rst_n = 1'b0;
    step(); step();
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst_res_sum", 32'(bus.res_sum), 0);
    chk("rst_sticky", 32'(ovf_sticky), 0);
    rst_n = 1'b1;
    step();
    set_req(1, 16'h1234, 16'h1111, 0, 0, 0);
    #1 chk("basic_ready0", 32'(bus.req0_ready), 1);
    step();
    set_req(0, 0, 0, 0, 0, 0);
    chk("basic_sum", 32'(bus.res_sum), 32'h2345);
    chk("basic_ovf", 32'(bus.res_ovf), 0);
    chk("basic_src", 32'(bus.res_src), 0);
    chk("basic_cnt", 32'(op_count), 1);
    set_req(0, 0, 0, 1, 16'h7777, 16'h1111);
    step();
    chk("satp_sum", 32'(bus.res_sum), 32'h7777);
    chk("satp_ovf", 32'(bus.res_ovf), 32'hF);
    chk("satp_src", 32'(bus.res_src), 1);
    chk("satp_sticky", 32'(ovf_sticky), 32'(STICKY));
    set_req(0, 0, 0, 1, 16'h8000, 16'h8000);
    step();
    chk("satn_sum", 32'(bus.res_sum), 32'h8000);
    chk("satn_ovf", 32'(bus.res_ovf), 32'h8);
    chk("satn_cnt", 32'(op_count), 3);
    set_req(0, 0, 0, 0, 0, 0);
    step();
    pulse_reset();
    set_req(1, 16'h0001, 16'h0001, 1, 16'h0010, 16'h0010);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_src", 32'(bus.res_src), 32'(i % 2));
      chk("rr_sum", 32'(bus.res_sum), (i % 2) ? 32'h0020 : 32'h0002);
      chk("rr_cnt", 32'(op_count), 32'(i + 1));
    end
    bus.res_ready = 1'b0;
    #1 chk("hold_ready0", 32'(bus.req0_ready), 0);
    chk("hold_ready1", 32'(bus.req1_ready), 0);
    step(); step();
    chk("hold_sum", 32'(bus.res_sum), 32'h0020);
    chk("hold_src", 32'(bus.res_src), 1);
    bus.res_ready = 1'b1;
    set_req(1, 16'h0003, 16'h0004, 0, 0, 0);
    #1 chk("drain_ready0", 32'(bus.req0_ready), 1);
    step();
    chk("drain_valid", 32'(bus.res_valid), 1);
    chk("drain_sum", 32'(bus.res_sum), 32'h0007);
    chk("drain_src", 32'(bus.res_src), 0);
    chk("drain_cnt", 32'(op_count), 5);
    set_req(0, 0, 0, 0, 0, 0);
    step();
    chk("empty_valid", 32'(bus.res_valid), 0);
    set_req(1, 16'h0007, 16'h0001, 0, 0, 0);
    clr_sticky = 1'b1;
    step();
    set_req(0, 0, 0, 0, 0, 0);
    chk("setclr_sticky", 32'(ovf_sticky), 32'(STICKY));
    chk("setclr_sum", 32'(bus.res_sum), 32'h0007);
    chk("setclr_ovf", 32'(bus.res_ovf), 32'h1);
    step();
    chk("clr_sticky", 32'(ovf_sticky), 0);
    clr_sticky = 1'b0;
    pulse_reset();
    set_req(1, 16'h0000, 16'h0000, 0, 0, 0);
    repeat (256) step();
    chk("wrap_cnt", 32'(op_count), 0);
    bus.res_ready = 1'b0;
    step();
    chk("full_before_rst", 32'(bus.res_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_valid", 32'(bus.res_valid), 0);
    chk("async_cnt", 32'(op_count), 0);
    chk("async_ready0", 32'(bus.req0_ready), 0);
    step();
    rst_n = 1'b1;
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/psa_arb.md
PSA_ARB -- requirements
Module: psa_arb

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the accepted-operation counter.
REQ-002 SHALL have port clk  input  1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1 each: requester N has an operand pair pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1 each: requester N's pair is accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  16 each: packed 4x4-bit signed operands, lane k = bits [4k+3:4k].
REQ-007 SHALL have port res_valid  output  1: result register holds a result.
REQ-008 SHALL have port res_ready  input  1: consumer takes the result this cycle.
REQ-009 SHALL have port res_sum  output  16: packed saturated sum.
REQ-010 SHALL have port res_src  output  1: requester index that produced res_sum.
REQ-011 SHALL have port res_ovf  output  4: per-lane saturation flags for res_sum.
REQ-012 SHALL have port clr_sticky  input  1: clears ovf_sticky.
REQ-013 SHALL have port ovf_sticky  output  1: any lane saturated since last clear.
REQ-014 SHALL have port op_count  output  CNT_W: number of accepted operations, modulo 2^CNT_W.

Function
REQ-015 SHALL compute each lane as signed 4-bit a+b; result >7 -> 0x7 with ovf=1; result <-8 -> 0x8 with ovf=1; otherwise true sum with ovf=0.
REQ-016 SHALL keep a two-state output register, EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-017 SHALL define slot_free = EMPTY, or FULL and res_ready=1; accept at most one request per cycle, only when slot_free.
REQ-018 SHALL arbitrate round-robin: only one valid -> grant it; both valid -> grant the requester not granted last; last-grant pointer updates only on acceptance.
REQ-019 SHALL drive reqN_ready = (grant==N) & reqN_valid & slot_free; readys depend on valids, never the reverse.
REQ-020 SHALL register sum, source and flags on acceptance; latency one cycle (accept at edge t -> res_valid at t+1).
REQ-021 SHALL transition FULL->EMPTY on res_ready with no acceptance; stay FULL with new contents on simultaneous drain and accept; EMPTY->FULL on accept.
REQ-022 SHALL hold res_sum/res_src/res_ovf stable while FULL and res_ready=0.
REQ-023 SHALL increment op_count on every acceptance, wrapping all-ones -> 0.
REQ-024 SHALL hold res_sum/res_src/res_ovf at their last value when EMPTY; their contents are don't-care to consumers.

Reset
REQ-025 SHALL on rst_n=0, independent of clk, force EMPTY, res_sum=0, res_src=0, res_ovf=0, ovf_sticky=0, op_count=0, last-grant=1 (requester 0 wins first contention).
REQ-026 SHALL discard any held result when reset asserts mid-operation; req0_ready/req1_ready are 0 while rst_n=0.

Configuration
REQ-027 SHALL with PSA_ARB_STICKY_EN defined: set ovf_sticky on acceptance of any result with res_ovf!=0, clear on clr_sticky; set wins over simultaneous clear.
REQ-028 SHALL with PSA_ARB_STICKY_EN undefined: tie ovf_sticky to 0 and ignore clr_sticky; all other behaviour unchanged.

Verification
REQ-029 SHALL cover: req0 a=0x1234 b=0x1111, res_ready=1 -> next cycle res_sum=0x2345, res_ovf=0x0, res_src=0, op_count=1.
REQ-030 SHALL cover: req1 a=0x7777 b=0x1111 -> res_sum=0x7777, res_ovf=0xF; a=0x8000 b=0x8000 -> res_sum=0x8000, res_ovf=0x8.
REQ-031 SHALL cover: both valid continuously after reset, res_ready=1 -> res_src sequence 0,1,0,1; one accept per cycle.
REQ-032 SHALL cover: res_ready=0 with result held -> both readys 0, res_* stable; raise res_ready with req0 valid -> drain and accept same cycle, state stays FULL.
REQ-033 SHALL cover: with PSA_ARB_STICKY_EN, clr_sticky in the same cycle as an overflowing acceptance -> ovf_sticky=1 next cycle; without the macro -> ovf_sticky stays 0.
REQ-034 SHALL cover: CNT_W=8, 256 accepts -> op_count=0; rst_n low while FULL -> res_valid=0 immediately, op_count=0.
